// File: rtl/div_issue_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : div_issue_pkg                                                |
// | Description : Op encodings, FSM states and result constants shared by the  |
// |               divider issue controller and its special-case decoder.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package div_issue_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/div_special_case.sv
// +----------------------------------------------------------------------------+
// | Module      : div_special_case                                             |
// | Description : Combinational detection of divide-by-zero and signed         |
// |               overflow, with the RV32M-defined result for each.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_special_case
   import div_issue_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        is_special,
   output logic [31:0] special_result
);

   logic div_by_zero;
   logic overflow;

   assign div_by_zero = (divisor == 32'd0);
   assign overflow    = !op[0] && (dividend == INT_MIN) && (divisor == 32'hFFFF_FFFF);
   assign is_special  = div_by_zero || overflow;

   always_comb begin
      special_result = 32'd0;
      if (div_by_zero)
         special_result = op[1] ? dividend : DIV0_QUOTIENT;
      else if (overflow)
         special_result = op[1] ? 32'd0 : INT_MIN;
   end

endmodule

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : div_issue_ctrl                                               |
// | Description : Execute-stage requester for the iterative divider. Resolves  |
// |               special cases locally, issues the rest, returns rd.          |
// |               Optional one-entry result cache: DIV_RESULT_CACHE_EN.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_issue_ctrl
   import div_issue_pkg::*;
#(
   parameter int DIV_TIMEOUT = 64
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_dividend,
   input  logic [31:0] req_divisor,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_error,
   output logic        div_start,
   output logic        div_is_signed,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_ready,
   input  logic        div_valid,
   input  logic        div_error,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder
);

   localparam int             CNT_W    = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DIV_TIMEOUT > 0) ? DIV_TIMEOUT - 1 : 0);

   state_t           state;
   state_t           state_nxt;
   logic             is_rem;
   logic [CNT_W-1:0] wd_cnt;
   logic             accept;
   logic             wd_expired;
   logic             is_special;
   logic [31:0]      special_result;
   logic             cache_hit;
   logic [31:0]      cache_result;

   div_special_case u_special (
      .op             (req_op),
      .dividend       (req_dividend),
      .divisor        (req_divisor),
      .is_special     (is_special),
      .special_result (special_result)
   );

   assign accept     = (state == IDLE) && req_valid && !flush;
   // wd_cnt holds the number of cycles elapsed since div_start
   assign wd_expired = (DIV_TIMEOUT != 0) && (wd_cnt >= CNT_LAST);

`ifdef DIV_RESULT_CACHE_EN
   logic        cache_valid;
   logic        cache_signed;
   logic [31:0] cache_dividend;
   logic [31:0] cache_divisor;
   logic [31:0] cache_quotient;
   logic [31:0] cache_remainder;

   assign cache_hit = cache_valid && !is_special && (cache_signed == !req_op[0]) &&
                      (cache_dividend == req_dividend) && (cache_divisor == req_divisor);
   assign cache_result = req_op[1] ? cache_remainder : cache_quotient;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid     <= 1'b0;
         cache_signed    <= 1'b0;
         cache_dividend  <= 32'd0;
         cache_divisor   <= 32'd0;
         cache_quotient  <= 32'd0;
         cache_remainder <= 32'd0;
      end else if (flush) begin
         cache_valid <= 1'b0;
      end else if ((state == WAIT) && div_valid && !div_error) begin
         cache_valid     <= 1'b1;
         cache_signed    <= div_is_signed;
         cache_dividend  <= div_dividend;
         cache_divisor   <= div_divisor;
         cache_quotient  <= div_quotient;
         cache_remainder <= div_remainder;
      end
   end
`else
   assign cache_hit    = 1'b0;
   assign cache_result = 32'd0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept)                    state_nxt = (is_special || cache_hit) ? RESP : ISSUE;
         ISSUE: if (flush)                     state_nxt = IDLE;
                else if (div_ready)            state_nxt = WAIT;
         WAIT:  if (flush)                     state_nxt = DRAIN;
                else if (div_valid || wd_expired) state_nxt = RESP;
         RESP:  if (flush || resp_ready)       state_nxt = IDLE;
         DRAIN: if (div_valid || wd_expired)   state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE) && !flush;
      div_start  = (state == ISSUE) && div_ready && !flush;
      resp_valid = (state == RESP);
   end

   // Operands are written only on accept so the divider sees them stable for its whole run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_rem        <= 1'b0;
         div_is_signed <= 1'b0;
         div_dividend  <= 32'd0;
         div_divisor   <= 32'd0;
         resp_result   <= 32'd0;
         resp_error    <= 1'b0;
         wd_cnt        <= '0;
      end else begin
         if (accept) begin
            is_rem        <= req_op[1];
            div_is_signed <= !req_op[0];
            div_dividend  <= req_dividend;
            div_divisor   <= req_divisor;
            resp_result   <= is_special ? special_result : cache_result;
            resp_error    <= 1'b0;
         end

         if (div_start)
            wd_cnt <= CNT_W'(1);
         else if ((state == WAIT) || (state == DRAIN))
            wd_cnt <= wd_cnt + CNT_W'(1);

         if ((state == WAIT) && !flush) begin
            if (div_valid) begin
               resp_result <= is_rem ? div_remainder : div_quotient;
               resp_error  <= div_error;
            end else if (wd_expired) begin
               resp_result <= 32'd0;
               resp_error  <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_div_issue_ctrl                                            |
// | Description : Scoreboard bench for div_issue_ctrl with a latency-          |
// |               configurable divider model.                                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_div_issue_ctrl;
   import div_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_dividend;
   logic [31:0] req_divisor;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_error;
   logic        div_start;
   logic        div_is_signed;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_ready;
   logic        div_valid;
   logic        div_error;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;

   div_issue_ctrl #(.DIV_TIMEOUT(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_result   (resp_result),
      .resp_error    (resp_error),
      .div_start     (div_start),
      .div_is_signed (div_is_signed),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_ready     (div_ready),
      .div_valid     (div_valid),
      .div_error     (div_error),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: div_valid arrives lat cycles after the div_start cycle
   int          lat = 33;
   bit          hang = 1'b0;
   bit          err_mode = 1'b0;
   bit          busy = 1'b0;
   int          m_cnt = 0;
   int          start_count = 0;
   int          start_cyc = 0;
   int          stable_err = 0;
   logic [31:0] cap_a = 32'd0;
   logic [31:0] cap_b = 32'd0;
   logic        cap_s = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy          <= 1'b0;
         div_ready     <= 1'b1;
         div_valid     <= 1'b0;
         div_error     <= 1'b0;
         div_quotient  <= 32'd0;
         div_remainder <= 32'd0;
      end else begin
         div_valid <= 1'b0;
         div_error <= 1'b0;
         if (div_start) begin
            start_count <= start_count + 1;
            start_cyc   <= cyc;
            if (!hang) begin
               busy      <= 1'b1;
               div_ready <= 1'b0;
               m_cnt     <= 1;
               cap_a     <= div_dividend;
               cap_b     <= div_divisor;
               cap_s     <= div_is_signed;
            end
         end else if (busy) begin
            if (div_dividend !== cap_a || div_divisor !== cap_b || div_is_signed !== cap_s)
               stable_err <= stable_err + 1;
            if (m_cnt == lat - 1) begin
               busy          <= 1'b0;
               div_ready     <= 1'b1;
               div_valid     <= 1'b1;
               div_error     <= err_mode;
               div_quotient  <= cap_s ? 32'($signed(cap_a) / $signed(cap_b)) : cap_a / cap_b;
               div_remainder <= cap_s ? 32'($signed(cap_a) % $signed(cap_b)) : cap_a % cap_b;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   // Scoreboard monitor, sampled on the falling edge
   logic [32:0] sb[$];
   int          hs_count = 0;
   int          rv_cycles = 0;
   int          dv_count = 0;
   int          dv_cyc = 0;
   int          valid_cyc = 0;
   logic        prev_rv = 1'b0;

   always @(negedge clk) begin
      logic [32:0] e;
      if (div_valid) begin
         dv_cyc   <= cyc;
         dv_count <= dv_count + 1;
      end
      if (resp_valid && !prev_rv) valid_cyc <= cyc;
      prev_rv <= resp_valid;
      if (resp_valid) rv_cycles <= rv_cycles + 1;
      if (rst_n && resp_valid && resp_ready && !flush) begin
         hs_count <= hs_count + 1;
         if (sb.size() == 0) begin
            check("unexpected_resp", 64'(resp_result), 64'hDEAD_0000);
         end else begin
            e = sb.pop_front();
            check("resp_result", 64'(resp_result), 64'(e[31:0]));
            check("resp_error", 64'(resp_error), 64'(e[32]));
         end
      end
   end

   int acc_cyc = 0;

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp, input logic exp_err);
      int g = 0;
      req_valid    = 1'b1;
      req_op       = op;
      req_dividend = a;
      req_divisor  = b;
      @(negedge clk);
      while (!req_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready)
         check("req_accept_timeout", 64'(req_ready), 64'd1);
      else if (push)
         sb.push_back({exp_err, exp});
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (sb.size() != 0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (sb.size() != 0) begin
         check("resp_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   int s0, hs0, rv0, dv0;

   initial begin
      rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
      req_dividend = 32'd0; req_divisor = 32'd0; resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_div_start", 64'(div_start), 64'd0);
      check("rst_resp_result", 64'(resp_result), 64'd0);
      check("rst_div_dividend", 64'(div_dividend), 64'd0);
      check("rst_div_is_signed", 64'(div_is_signed), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      s0 = start_count;
      send(OP_DIV, 32'd100, 32'd7, 1, 32'd14, 1'b0);
      wait_done();
      check("div_starts", 64'(start_count - s0), 64'd1);
      check("div_latency", 64'(dv_cyc - start_cyc), 64'd33);
      check("resp_latency", 64'(valid_cyc - dv_cyc), 64'd1);

      s0 = start_count;
      send(OP_REM, 32'd100, 32'd7, 1, 32'd2, 1'b0);
      wait_done();
`ifdef DIV_RESULT_CACHE_EN
      check("rem_starts", 64'(start_count - s0), 64'd0);
`else
      check("rem_starts", 64'(start_count - s0), 64'd1);
`endif

      s0 = start_count;
      send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
      wait_done();
      check("ovf_latency", 64'(valid_cyc - acc_cyc), 64'd0);
      send(OP_REMU, 32'd5, 32'd0, 1, 32'd5, 1'b0);
      wait_done();
      check("rem0_latency", 64'(valid_cyc - acc_cyc), 64'd0);
      check("special_starts", 64'(start_count - s0), 64'd0);

      send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 1'b0);
      wait_done();
      send(OP_REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 1'b0);
      wait_done();

      err_mode = 1'b1;
      send(OP_DIVU, 32'd8, 32'd2, 1, 32'd4, 1'b1);
      wait_done();
      err_mode = 1'b0;

      // Flush three cycles after start: late div_valid must be swallowed
      hs0 = hs_count; rv0 = rv_cycles; dv0 = dv_count;
      send(OP_DIVU, 32'd50, 32'd5, 0, 32'd0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      for (int g = 0; g < 100 && dv_count == dv0; g++) begin @(posedge clk); #1; end
      repeat (3) begin @(posedge clk); #1; end
      check("drain_div_valid", 64'(dv_count - dv0), 64'd1);
      check("drain_no_resp", 64'(rv_cycles - rv0), 64'd0);
      check("drain_no_hs", 64'(hs_count - hs0), 64'd0);
      send(OP_DIVU, 32'd9, 32'd3, 1, 32'd3, 1'b0);
      wait_done();

      // Flush while the result is waiting drops it
      hs0 = hs_count;
      resp_ready = 1'b0;
      send(OP_REMU, 32'd5, 32'd0, 0, 32'd0, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("resp_flush_drop", 64'(resp_valid), 64'd0);
      @(posedge clk); #1 resp_ready = 1'b1;
      check("resp_flush_no_hs", 64'(hs_count - hs0), 64'd0);

      // Flush in IDLE blocks acceptance
      s0 = start_count; rv0 = rv_cycles;
      flush = 1'b1; req_valid = 1'b1; req_op = OP_DIVU;
      req_dividend = 32'd9; req_divisor = 32'd3;
      @(negedge clk);
      check("idle_flush_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("idle_flush_starts", 64'(start_count - s0), 64'd0);
      check("idle_flush_resp", 64'(rv_cycles - rv0), 64'd0);

      hang = 1'b1;
      send(OP_DIV, 32'd20, 32'd4, 1, 32'd0, 1'b1);
      wait_done();
      check("timeout_latency", 64'(valid_cyc - start_cyc), 64'd64);
      hang = 1'b0;

      send(OP_DIV, 32'd1000, 32'd3, 1, 32'd333, 1'b0);
      wait_done();
      s0 = start_count;
      resp_ready = 1'b0;
      send(OP_REM, 32'd1000, 32'd3, 1, 32'd1, 1'b0);
      for (int g = 0; g < 100 && !resp_valid; g++) @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("hold_valid", 64'(resp_valid), 64'd1);
         check("hold_result", 64'(resp_result), 64'd1);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      wait_done();
`ifdef DIV_RESULT_CACHE_EN
      check("cache_rem_starts", 64'(start_count - s0), 64'd0);
`else
      check("cache_rem_starts", 64'(start_count - s0), 64'd1);
`endif

      check("operand_stable", 64'(stable_err), 64'd0);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
